// File: rtl/dmem_bridge.sv
// dmem_bridge: turns a MEM-stage access into a one-outstanding cache handshake, stalls the pipeline until the cache responds, then holds the result until MEM/WB advances
module dmem_bridge #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_rmask,
  input  logic [3:0]  cpu_wmask,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_advance,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic req;
  logic [CW-1:0] cnt;
  assign req = cpu_valid & (|cpu_rmask | |cpu_wmask);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = req ? BUSY : IDLE;
      BUSY: state_nx = mem_resp ? DONE : BUSY;
      DONE: state_nx = cpu_advance ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    cpu_stall = rst & ((state == IDLE) ? req : (state == BUSY));
    mem_read = (state == BUSY) & |mem_rmask;
    mem_write = (state == BUSY) & |mem_wmask;
  end
  // A store wins when both masks are set, so the read mask is dropped at latch time.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_address <= '0;
      mem_rmask <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        mem_address <= {cpu_addr[31:2], 2'b00};
        mem_rmask <= |cpu_wmask ? 4'b0000 : cpu_rmask;
        mem_wmask <= cpu_wmask;
        mem_wdata <= cpu_wdata;
        cnt <= '0;
      end
      if (state == BUSY && mem_resp) cpu_rdata <= mem_rdata;
      if (state == BUSY && !mem_resp && cnt != CW'(TIMEOUT)) cnt <= cnt + CW'(1);
      if (state == BUSY && !mem_resp && cnt == CW'(TIMEOUT - 1)) err_timeout <= 1'b1;
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed table plus randomized transactions checked against a transaction-level model of the bridge
module tb_dmem_bridge;
  localparam int TO = 8;
  logic clk, rst, cpu_valid, cpu_advance, cpu_stall, mem_read, mem_write, mem_resp, err_timeout;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_address, mem_wdata, mem_rdata;
  logic [3:0] cpu_rmask, cpu_wmask, mem_rmask, mem_wmask;
  int checks = 0, errors = 0;
  logic err_exp = 1'b0;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    int          hold;
    bit          gap;
  } txn_t;
  txn_t tbl[5];
  dmem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_rmask(cpu_rmask),
    .cpu_wmask(cpu_wmask), .cpu_wdata(cpu_wdata), .cpu_advance(cpu_advance), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .err_timeout(err_timeout)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle_inputs();
    cpu_valid = 1'b0; cpu_addr = '0; cpu_rmask = '0; cpu_wmask = '0; cpu_wdata = '0;
    cpu_advance = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
  endtask
  task automatic scramble_cpu();
    cpu_valid = 1'($urandom); cpu_addr = $urandom; cpu_rmask = 4'($urandom);
    cpu_wmask = 4'($urandom); cpu_wdata = $urandom;
  endtask
  // Model: a store wins; the access takes one detect cycle, waits+1 busy cycles, then hold+1 result cycles.
  task automatic run_txn(input txn_t t);
    logic is_w;
    logic [3:0] exp_rm;
    int stalls;
    is_w = |t.wm;
    exp_rm = is_w ? 4'b0000 : t.rm;
    stalls = 0;
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_addr = t.addr; cpu_rmask = t.rm; cpu_wmask = t.wm; cpu_wdata = t.wd;
    cpu_advance = 1'b0; mem_resp = 1'b0; mem_rdata = $urandom;
    #1;
    stalls += int'(cpu_stall);
    chk("idle_req_stall", 32'(cpu_stall), 1);
    chk("idle_strobes", {mem_read, mem_write}, 0);
    for (int k = 0; k <= t.waits; k++) begin
      @(posedge clk); #1;
      scramble_cpu();
      cpu_advance = 1'($urandom);
      mem_resp = (k == t.waits);
      mem_rdata = (k == t.waits) ? t.rd : $urandom;
      #1;
      stalls += int'(cpu_stall);
      chk("busy_addr", mem_address, t.addr & 32'hFFFF_FFFC);
      chk("busy_read", 32'(mem_read), 32'(exp_rm != 0));
      chk("busy_write", 32'(mem_write), 32'(is_w));
      chk("busy_rmask", 32'(mem_rmask), 32'(exp_rm));
      chk("busy_wmask", 32'(mem_wmask), 32'(t.wm));
      chk("busy_wdata", mem_wdata, t.wd);
      chk("busy_err", 32'(err_timeout), 32'(err_exp | (k >= TO)));
    end
    if (t.waits >= TO) err_exp = 1'b1;
    for (int d = 0; d <= t.hold; d++) begin
      @(posedge clk); #1;
      scramble_cpu();
      cpu_advance = (d == t.hold);
      mem_resp = 1'($urandom);
      mem_rdata = $urandom;
      #1;
      stalls += int'(cpu_stall);
      chk("done_rdata", cpu_rdata, t.rd);
      chk("done_strobes", {mem_read, mem_write}, 0);
      chk("done_err", 32'(err_timeout), 32'(err_exp));
    end
    chk("stall_cycles", 32'(stalls), 32'(t.waits + 2));
    if (t.gap) begin
      @(posedge clk); #1;
      idle_inputs();
      cpu_valid = 1'($urandom);
      mem_resp = 1'($urandom);
      #1;
      chk("idle_stall", 32'(cpu_stall), 0);
      chk("idle_strobes", {mem_read, mem_write}, 0);
      chk("idle_rdata", cpu_rdata, t.rd);
    end
  endtask
  initial begin
    txn_t r;
    tbl[0] = '{32'h4000_0106, 4'b0100, 4'b0000, 32'h0000_0000, 32'hAABB_CCDD, 2, 0, 1'b1};
    tbl[1] = '{32'h0000_1000, 4'b0000, 4'b1111, 32'h1234_5678, 32'h0BAD_F00D, 0, 0, 1'b0};
    tbl[2] = '{32'h0000_2008, 4'b1111, 4'b0000, 32'h0000_0000, 32'h5A5A_1234, 1, 5, 1'b1};
    tbl[3] = '{32'h0000_300C, 4'b1111, 4'b0011, 32'hCAFE_BABE, 32'h1111_2222, 0, 1, 1'b1};
    tbl[4] = '{32'h0000_0003, 4'b0001, 4'b0000, 32'h0000_0000, 32'h7777_0001, 3, 2, 1'b0};
    rst = 1'b0;
    idle_inputs();
    #2;
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_err", 32'(err_timeout), 0);
    #10 rst = 1'b1;
    for (int i = 0; i < 5; i++) run_txn(tbl[i]);
    // Non-memory instructions never leave IDLE.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      cpu_valid = 1'b1; cpu_addr = $urandom; cpu_wdata = $urandom;
      #1;
      chk("nonmem_stall", 32'(cpu_stall), 0);
      chk("nonmem_strobes", {mem_read, mem_write}, 0);
    end
    for (int i = 0; i < 40; i++) begin
      r.addr = $urandom; r.rm = 4'($urandom); r.wm = 4'($urandom); r.wd = $urandom; r.rd = $urandom;
      if (r.rm == 0 && r.wm == 0) r.rm = 4'b0010;
      r.waits = $urandom_range(0, 5); r.hold = $urandom_range(0, 3); r.gap = 1'($urandom);
      run_txn(r);
    end
    r = '{32'h0000_4444, 4'b1111, 4'b0000, 32'h0, 32'hDEAD_BEEF, 10, 1, 1'b1};
    run_txn(r);
    chk("err_sticky", 32'(err_timeout), 1);
    @(posedge clk); #1;
    idle_inputs();
    cpu_valid = 1'b1; cpu_addr = 32'h0000_0055; cpu_rmask = 4'hF;
    @(posedge clk); #1;
    #1;
    chk("pre_rst_read", 32'(mem_read), 1);
    chk("pre_rst_stall", 32'(cpu_stall), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_strobes", {mem_read, mem_write}, 0);
    chk("async_rst_stall", 32'(cpu_stall), 0);
    chk("async_rst_err", 32'(err_timeout), 0);
    chk("async_rst_rdata", cpu_rdata, 0);
    chk("async_rst_addr", mem_address, 0);
    err_exp = 1'b0;
    idle_inputs();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b1; mem_rdata = 32'hFFFF_0000;
    #1;
    chk("spurious_stall", 32'(cpu_stall), 0);
    @(posedge clk); #1;
    mem_resp = 1'b0;
    #1;
    chk("spurious_strobes", {mem_read, mem_write}, 0);
    chk("spurious_rdata", cpu_rdata, 0);
    r = '{32'h0000_8001, 4'b0011, 4'b0000, 32'h0, 32'h0F0F_0F0F, 1, 0, 1'b1};
    run_txn(r);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits between the pipeline's MEM stage and the data cache.
- Converts the MEM stage's single-cycle request (address, rmask, wmask, wdata) into a one-outstanding read/write handshake with the cache.
- Stalls the pipeline until the cache responds.
- Holds the returned read data stable until the hazard controller advances MEM/WB, so a held request is never reissued.

Parameters:
TIMEOUT, 1024, cycles in BUSY without mem_resp before err_timeout sets; counter width is $clog2(TIMEOUT+1).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
cpu_valid  in  1  MEM stage holds a valid instruction
cpu_addr  in  32  byte address from MEM stage
cpu_rmask  in  4  byte read mask, nonzero means load
cpu_wmask  in  4  byte write mask, nonzero means store
cpu_wdata  in  32  store data, already lane-shifted
cpu_advance  in  1  hazard ctrl loads MEM/WB this cycle
cpu_rdata  out  32  load data to MEM/WB
cpu_stall  out  1  bridge requires pipeline hold
mem_address  out  32  word-aligned cache address
mem_read  out  1  cache read strobe
mem_write  out  1  cache write strobe
mem_rmask  out  4  byte read mask to cache
mem_wmask  out  4  byte write mask to cache
mem_wdata  out  32  store data to cache
mem_rdata  in  32  cache read data
mem_resp  in  1  cache completion, single-cycle pulse
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including cpu_rdata, mem_address, err_timeout; watchdog counter=0. A request in flight is abandoned; the cache side is expected to be reset together.
- Request: req = cpu_valid & (|cpu_rmask | |cpu_wmask).
- Write priority: if both masks are nonzero, the access is a write and the latched rmask is forced to 0.
- States:
  - IDLE:
    - cpu_stall = req, combinational.
    - On req: latch {cpu_addr[31:2],2'b00}, masks and wdata into registers; go to BUSY.
    - No req: stay; cpu_stall=0 and cpu_rdata holds its last value.
  - BUSY:
    - mem_read = (latched rmask != 0); mem_write = (latched wmask != 0). Both come from registers; they are held constant with address, masks and wdata until mem_resp.
    - cpu_stall=1.
    - On mem_resp: capture mem_rdata into the cpu_rdata register (writes capture the value too; it is don't-care); deassert strobes next cycle; go to DONE.
    - Watchdog counter increments each BUSY cycle without resp. When it reaches TIMEOUT, err_timeout=1 (sticky until reset) and the bridge keeps waiting.
  - DONE:
    - cpu_stall=0; cpu_rdata stable; strobes=0.
    - If cpu_advance: go to IDLE. Otherwise stay; the instruction is other-stalled and is not reissued.
- Latency: minimum 3 cycles per access (IDLE detect, BUSY with same-cycle resp, DONE). Each added cache wait adds 1 cycle.
- Back-to-back: the cycle after DONE+advance is IDLE and may detect the next req immediately. There are no gaps beyond that.
- cpu_valid or masks changing during BUSY/DONE: ignored; the latched request completes.
- mem_resp in IDLE or DONE: spurious, ignored, no state change.
- Watchdog counter clears on entry to BUSY.
- Non-memory instructions (masks 0) pass with cpu_stall=0 and never leave IDLE.

Test Plan:
- Reset then cpu_valid=1, addr=0x40000106, rmask=0100, resp after 2 wait cycles with rdata=0xAABBCCDD, cpu_advance=1 in DONE -> mem_address=0x40000104, mem_read=1 for 3 cycles, stall high 4 cycles, cpu_rdata=0xAABBCCDD in DONE, back to IDLE.
- Store addr=0x1000, wmask=1111, wdata=0x12345678, resp in first BUSY cycle -> mem_write=1 exactly 1 cycle, mem_wdata=0x12345678, total 3 cycles, mem_read never 1.
- Load completes, cpu_advance=0 for 5 cycles in DONE -> stall=0, mem_read stays 0 (no reissue), cpu_rdata constant, then advance -> IDLE.
- rmask=1111 and wmask=0011 together -> mem_write=1, mem_read=0, mem_rmask=0000.
- TIMEOUT=8, mem_resp withheld -> err_timeout rises after 8 BUSY cycles, stall stays 1. A later resp completes the access; err_timeout stays 1.
- Assert rst=0 mid-BUSY asynchronously -> strobes, stall and err_timeout drop to 0 without a clock edge; spurious mem_resp in IDLE is ignored.
